p_inside: RTL and testbench

//  Point-in-triangle stage directly downstream of p_hit. Takes the ray/plane hit point plus

---
 rtl/ray_pkg.sv | 15 +
 rtl/fifo_fwft.sv | 40 ++++
 rtl/p_inside.sv | 80 ++++++++
 tb/tb_p_inside.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// ray_pkg: shared fixed-point defaults and ray/triangle types
package ray_pkg;
  localparam int RAY_D_BITS = 32;
  localparam int RAY_Q_BITS = 16;
  localparam int RAY_FIFO_DEPTH = 8;
  typedef struct packed {
    logic signed [RAY_D_BITS-1:0] x;
    logic signed [RAY_D_BITS-1:0] y;
    logic signed [RAY_D_BITS-1:0] z;
  } vec3_t;
  typedef struct packed {
    logic hit;
    vec3_t p;
  } hit_entry_t;
endpackage

// File: rtl/fifo_fwft.sv
// fifo_fwft: show-ahead FIFO exposing its occupancy count
module fifo_fwft
  import ray_pkg::*;
#(
  parameter int WIDTH = 1 + 3*RAY_D_BITS,
  parameter int DEPTH = RAY_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     empty,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop;
  assign empty = count == '0;
  assign pop = rd_en && !empty;
  assign push = wr_en && (count != CW'(DEPTH) || pop);
  assign rd_data = empty ? '0 : mem[rp];
  // storage array, written at the tail
  always_ff @(posedge clock)
    if (push) mem[wp] <= wr_data;
  // pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/p_inside.sv
// p_inside: five-stage point-in-triangle edge test feeding a credit-managed result FIFO
module p_inside
  import ray_pkg::*;
#(
  parameter int D_BITS = RAY_D_BITS,
  parameter int Q_BITS = RAY_Q_BITS,
  parameter int FIFO_DEPTH = RAY_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3*D_BITS-1:0]   p_hit,
  input  logic [3*D_BITS-1:0]   v0,
  input  logic [3*D_BITS-1:0]   v1,
  input  logic [3*D_BITS-1:0]   v2,
  input  logic [3*D_BITS-1:0]   tri_normal,
  input  logic                  in_wr_en,
  output logic                  in_full,
  input  logic                  out_rd_en,
  output logic                  out_empty,
  output logic                  hit,
  output logic [3*D_BITS-1:0]   p_out
);
  localparam int D2 = 2*D_BITS;
  localparam int D3 = 3*D_BITS;
  logic signed [D_BITS-1:0] pi [3], ni [3], vt [3][3];
  logic signed [D_BITS-1:0] e [3][3], d [3][3], n1 [3], n2 [3], n3 [3];
  logic signed [D2-1:0] m [3][6], c [3][3];
  logic signed [D3-1:0] q [3][3], s [3];
  logic [D3-1:0] p1, p2, p3, p4, p5;
  logic [4:0] vld;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic accept, hit5;
  genvar i;
  for (i = 0; i < 3; i++) begin : g_unpack
    assign pi[i] = p_hit[(3-i)*D_BITS-1 -: D_BITS];
    assign ni[i] = tri_normal[(3-i)*D_BITS-1 -: D_BITS];
    assign vt[0][i] = v0[(3-i)*D_BITS-1 -: D_BITS];
    assign vt[1][i] = v1[(3-i)*D_BITS-1 -: D_BITS];
    assign vt[2][i] = v2[(3-i)*D_BITS-1 -: D_BITS];
  end
  assign in_full = int'(count) + $countones(vld) >= FIFO_DEPTH;
  assign accept = in_wr_en && !in_full;
  assign hit5 = !(s[0][D3-1] | s[1][D3-1] | s[2][D3-1]);
  // valid bits travel with the data; reset discards everything in flight
  always_ff @(posedge clock or posedge reset)
    if (reset) vld <= '0;
    else vld <= {vld[3:0], accept};
  // datapath: edges/offsets, cross products, projection onto the normal, per-edge sums
  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) begin
        e[k][j] <= vt[(k+1)%3][j] - vt[k][j];
        d[k][j] <= pi[j] - vt[k][j];
        m[k][2*j] <= D2'(e[k][(j+1)%3]) * D2'(d[k][(j+2)%3]);
        m[k][2*j+1] <= D2'(e[k][(j+2)%3]) * D2'(d[k][(j+1)%3]);
        c[k][j] <= (m[k][2*j] - m[k][2*j+1]) >>> Q_BITS;
        q[k][j] <= D3'(c[k][j]) * D3'(n3[j]);
      end
    for (int k = 0; k < 3; k++)
      s[k] <= q[k][0] + q[k][1] + q[k][2];
    n1 <= ni;
    n2 <= n1;
    n3 <= n2;
    p1 <= p_hit;
    p2 <= p1;
    p3 <= p2;
    p4 <= p3;
    p5 <= p4;
  end
  fifo_fwft #(.WIDTH(1 + D3), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (vld[4]),
    .wr_data ({hit5, p5}),
    .rd_en   (out_rd_en),
    .empty   (out_empty),
    .rd_data ({hit, p_out}),
    .count   (count)
  );
endmodule

// File: tb/tb_p_inside.sv
// tb_p_inside: randomized bench against a queue-based model of p_inside
module tb_p_inside;
  logic clock = 0, reset = 1;
  logic [95:0] p_hit, v0, v1, v2, tri_normal, p_out;
  logic in_wr_en = 0, out_rd_en = 0;
  logic in_full, out_empty, hit;
  int errors = 0, checks = 0, cyc = 0;

  typedef struct { bit h; logic [95:0] p; int rdy; } ent_t;
  ent_t mq[$];
  bit vis;

  p_inside dut (
    .clock(clock), .reset(reset), .p_hit(p_hit), .v0(v0), .v1(v1), .v2(v2),
    .tri_normal(tri_normal), .in_wr_en(in_wr_en), .in_full(in_full),
    .out_rd_en(out_rd_en), .out_empty(out_empty), .hit(hit), .p_out(p_out)
  );

  always #5 clock = ~clock;

  function automatic logic [95:0] vec(int x, int y, int z);
    return {32'(x), 32'(y), 32'(z)};
  endfunction

  function automatic longint cmp(logic [95:0] v, int i);
    logic signed [31:0] w;
    w = v[(3-i)*32-1 -: 32];
    return longint'(w);
  endfunction

  // inside (or on an edge) iff ((b-a) x (p-a)) . n >= 0 for all three edges a->b
  function automatic bit model_hit(logic [95:0] pp, a0, a1, a2, nn);
    longint ax, ay, bx, by, az, bz, px, py, pz, ex, ey, ez, dx, dy, dz, s;
    logic [95:0] va, vb;
    for (int k = 0; k < 3; k++) begin
      va = k == 0 ? a0 : k == 1 ? a1 : a2;
      vb = k == 0 ? a1 : k == 1 ? a2 : a0;
      ax = cmp(va, 0); ay = cmp(va, 1); az = cmp(va, 2);
      bx = cmp(vb, 0); by = cmp(vb, 1); bz = cmp(vb, 2);
      px = cmp(pp, 0); py = cmp(pp, 1); pz = cmp(pp, 2);
      ex = bx - ax; ey = by - ay; ez = bz - az;
      dx = px - ax; dy = py - ay; dz = pz - az;
      s = ((ey*dz - ez*dy) >>> 16) * cmp(nn, 0)
        + ((ez*dx - ex*dz) >>> 16) * cmp(nn, 1)
        + ((ex*dy - ey*dx) >>> 16) * cmp(nn, 2);
      if (s < 0) return 0;
    end
    return 1;
  endfunction

  task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // model: every accepted test becomes visible 5 edges later, in order
  always @(posedge clock or posedge reset)
    if (reset) mq.delete();
    else begin
      bit pop, acc;
      pop = out_rd_en && mq.size() > 0 && mq[0].rdy <= cyc;
      acc = in_wr_en && mq.size() < 8;
      cyc++;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{model_hit(p_hit, v0, v1, v2, tri_normal), p_hit, cyc + 5});
    end

  // compare DUT outputs with the model every cycle
  always @(negedge clock)
    if (!reset) begin
      vis = mq.size() > 0 && mq[0].rdy <= cyc;
      chk("out_empty", out_empty, !vis);
      chk("in_full", in_full, mq.size() >= 8);
      if (vis) begin
        chk("hit", hit, mq[0].h);
        chk("p_out", p_out, mq[0].p);
      end
    end

  task automatic std_tri();
    v0 = vec(0, 0, 0); v1 = vec('h10000, 0, 0); v2 = vec(0, 'h10000, 0);
    tri_normal = vec(0, 0, 'h10000);
  endtask

  function automatic int rc();
    return int'($urandom_range(0, 'h80000)) - 'h40000;
  endfunction

  task automatic step(bit wr, bit rd, logic [95:0] p);
    in_wr_en = wr; out_rd_en = rd; p_hit = p;
    @(negedge clock);
  endtask

  task automatic drain();
    for (int k = 0; k < 14; k++) step(0, 1, p_hit);
  endtask

  int lat, acc_n, full_n, pops;

  initial begin
    std_tri();
    p_hit = '0;
    #1;
    chk("rst_empty", out_empty, 1);
    chk("rst_full", in_full, 0);
    chk("rst_hit", hit, 0);
    chk("rst_pout", p_out, 0);
    chk("model_in", model_hit(vec('h4000, 'h4000, 0), v0, v1, v2, tri_normal), 1);
    chk("model_out", model_hit(vec('h10000, 'h10000, 0), v0, v1, v2, tri_normal), 0);
    chk("model_edge", model_hit(vec('h8000, 0, 0), v0, v1, v2, tri_normal), 1);
    chk("model_vtx", model_hit(v2, v0, v1, v2, tri_normal), 1);
    chk("model_degen", model_hit(vec('h4000, 0, 0), v1, v1, v1, tri_normal), 1);
    repeat (2) @(negedge clock);
    reset = 0;
    @(negedge clock);
    // single push latency
    step(1, 0, vec('h4000, 'h4000, 0));
    in_wr_en = 0; lat = 0;
    while (out_empty && lat < 20) begin @(negedge clock); lat++; end
    chk("latency", lat, 5);
    chk("t1_hit", hit, 1);
    chk("t1_pout", p_out, vec('h4000, 'h4000, 0));
    drain();
    // outside, on-edge, vertex
    step(1, 0, vec('h10000, 'h10000, 0));
    step(1, 0, vec('h8000, 0, 0));
    step(1, 0, vec(0, 'h10000, 0));
    step(0, 0, p_hit);
    repeat (4) step(0, 0, p_hit);
    chk("t2_out", hit, 0);
    step(0, 1, p_hit);
    chk("t2_edge", hit, 1);
    step(0, 1, p_hit);
    chk("t2_vtx", hit, 1);
    drain();
    // streaming with continuous pops
    full_n = 0; pops = 0;
    for (int k = 0; k < 100; k++) begin
      if (in_full) full_n++;
      if (!out_empty) pops++;
      step(1, 1, vec(int'($urandom_range(0, 'h18000)) - 'h4000,
                     int'($urandom_range(0, 'h18000)) - 'h4000, rc()));
    end
    for (int k = 0; k < 10; k++) begin
      if (!out_empty) pops++;
      step(0, 1, p_hit);
    end
    chk("t3_full_seen", full_n, 0);
    chk("t3_results", pops, 100);
    // credit limit
    acc_n = 0;
    for (int k = 0; k < 16; k++) begin
      in_wr_en = 1; out_rd_en = 0; p_hit = vec(rc(), rc(), 0);
      if (!in_full) acc_n++;
      @(negedge clock);
    end
    chk("t4_accepted", acc_n, 8);
    chk("t4_full", in_full, 1);
    step(0, 1, p_hit);
    chk("t4_full_drop", in_full, 0);
    in_wr_en = 1; out_rd_en = 0; p_hit = vec('h2000, 'h2000, 0);
    chk("t4_credit", !in_full, 1);
    @(negedge clock);
    chk("t4_refull", in_full, 1);
    // push and pop together near full, then random traffic and triangles
    for (int k = 0; k < 40; k++) step(1, 1, vec(rc(), rc(), rc()));
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        v0 = vec(rc(), rc(), rc()); v1 = v0; v2 = v0;
      end else begin
        v0 = vec(rc(), rc(), rc()); v1 = vec(rc(), rc(), rc()); v2 = vec(rc(), rc(), rc());
      end
      tri_normal = vec(rc(), rc(), rc());
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1), vec(rc(), rc(), rc()));
    end
    std_tri();
    drain();
    // reset with queued and in-flight entries
    for (int k = 0; k < 3; k++) step(1, 0, vec(rc(), rc(), 0));
    repeat (6) step(0, 0, p_hit);
    for (int k = 0; k < 2; k++) step(1, 0, vec(rc(), rc(), 0));
    in_wr_en = 0;
    #2 reset = 1;
    #1;
    chk("t6_empty", out_empty, 1);
    chk("t6_full", in_full, 0);
    @(negedge clock);
    reset = 0;
    step(1, 0, vec('h4000, 'h2000, 0));
    in_wr_en = 0; lat = 0;
    while (out_empty && lat < 20) begin @(negedge clock); lat++; end
    chk("t6_latency", lat, 5);
    chk("t6_hit", hit, 1);
    chk("t6_pout", p_out, vec('h4000, 'h2000, 0));
    step(0, 1, p_hit);
    repeat (8) step(0, 0, p_hit);
    chk("t6_only", out_empty, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
